// File: rtl/clk_gate_sequencer.sv
// clk_gate_sequencer: applies requested clock-gate changes one domain at a time.
// A domain is gated only after it reports idle, and every change is followed by a settle interval.
module clk_gate_sequencer #(
   parameter int N       = 9,
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_gate,
   input  logic [N-1:0] domain_idle,
   input  logic         err_clr,
   output logic [N-1:0] gate_en,
   output logic         busy,
   output logic [3:0]   cur_domain,
   output logic [N-1:0] err_sticky
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_APPLY, S_SETTLE} state_t;
   localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
   state_t state, state_n;
   logic [N-1:0] req_q, skip, pending, cur_mask, to_mask;
   logic [3:0] sel;
   logic [15:0] tcnt;
   logic [SW-1:0] scnt;
   logic target, idle_q, req_cur, idle_cur, hit_idle, abort, timeout, settle_done;
   assign pending     = (req_gate ^ gate_en) & ~skip;
   assign req_cur     = req_gate[cur_domain];
   assign idle_cur    = domain_idle[cur_domain];
   assign hit_idle    = idle_cur && idle_q;
   assign abort       = req_cur != target;
   assign timeout     = tcnt == 16'(TIMEOUT - 1);
   assign settle_done = scnt == SW'(SETTLE - 1);
   assign cur_mask    = N'(1) << cur_domain;
   assign to_mask     = (state == S_WAIT && !abort && !hit_idle && timeout) ? cur_mask : '0;
   assign busy        = state != S_IDLE;
   always_comb begin
      sel = '0;
      for (int i = N - 1; i >= 0; i--) if (pending[i]) sel = 4'(i);
   end
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   state_n = |pending ? (req_gate[sel] ? S_WAIT : S_APPLY) : S_IDLE;
         S_WAIT:   state_n = abort ? S_IDLE : hit_idle ? S_APPLY : timeout ? S_IDLE : S_WAIT;
         S_APPLY:  state_n = S_SETTLE;
         S_SETTLE: state_n = settle_done ? S_IDLE : S_SETTLE;
         default:  state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end
   // idle_q remembers whether the previous waiting cycle already saw the domain idle
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q      <= '0;
         skip       <= '0;
         err_sticky <= '0;
         gate_en    <= '0;
         cur_domain <= '0;
         target     <= 1'b0;
         idle_q     <= 1'b0;
         tcnt       <= '0;
         scnt       <= '0;
      end else begin
         req_q      <= req_gate;
         skip       <= (skip & ~(req_gate ^ req_q)) | to_mask;
         err_sticky <= (err_clr ? '0 : err_sticky) | to_mask;
         idle_q     <= state == S_WAIT && idle_cur;
         tcnt       <= state == S_WAIT ? tcnt + 16'd1 : '0;
         scnt       <= state == S_SETTLE ? scnt + SW'(1) : '0;
         if (state == S_IDLE && |pending) begin
            cur_domain <= sel;
            target     <= req_gate[sel];
         end
         if (state == S_APPLY) gate_en[cur_domain] <= target;
      end
   end
endmodule

// File: tb/tb_clk_gate_sequencer.sv
// tb_clk_gate_sequencer: pinned scenarios plus randomized traffic, checked every cycle
// against a behavioural model of the sequencing rules.
module tb_clk_gate_sequencer;
   localparam int N = 9, SETTLE = 4, TIMEOUT = 16;
   logic clk = 1'b0, rst = 1'b1, err_clr = 1'b0;
   logic [N-1:0] req_gate = '0, domain_idle = '0, stuck = '1;
   logic [N-1:0] gate_en, err_sticky;
   logic busy;
   logic [3:0] cur_domain;
   int n_vec = 0, n_err = 0;
   bit chk_en = 0;

   clk_gate_sequencer #(.N(N), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req_gate(req_gate), .domain_idle(domain_idle), .err_clr(err_clr),
      .gate_en(gate_en), .busy(busy), .cur_domain(cur_domain), .err_sticky(err_sticky));

   always #5 clk = ~clk;

   typedef enum {M_IDLE, M_WAIT, M_APPLY, M_SETTLE} phase_t;
   phase_t phase = M_IDLE;
   logic [N-1:0] m_gate = '0, m_err = '0, m_skip = '0, m_req_q = '0;
   int m_cur = 0, streak = 0, waited = 0, settle_left = 0;
   bit m_tgt = 0;

   always @(posedge clk) begin
      logic [N-1:0] pend;
      if (rst) begin
         phase = M_IDLE; m_gate = '0; m_err = '0; m_skip = '0; m_req_q = '0; m_cur = 0;
      end else begin
         pend = (req_gate ^ m_gate) & ~m_skip;
         m_skip = m_skip & ~(req_gate ^ m_req_q);
         m_req_q = req_gate;
         if (err_clr) m_err = '0;
         case (phase)
            M_IDLE: if (pend != '0) begin
               for (int i = 0; i < N; i++) if (pend[i]) begin m_cur = i; break; end
               m_tgt = req_gate[m_cur];
               streak = 0;
               waited = 0;
               phase = m_tgt ? M_WAIT : M_APPLY;
            end
            M_WAIT: if (req_gate[m_cur] != m_tgt) phase = M_IDLE;
            else begin
               streak = domain_idle[m_cur] ? streak + 1 : 0;
               if (streak >= 2) phase = M_APPLY;
               else if (waited == TIMEOUT - 1) begin
                  m_err[m_cur] = 1'b1; m_skip[m_cur] = 1'b1; phase = M_IDLE;
               end else waited++;
            end
            M_APPLY: begin m_gate[m_cur] = m_tgt; settle_left = SETTLE; phase = M_SETTLE; end
            M_SETTLE: begin settle_left--; if (settle_left == 0) phase = M_IDLE; end
         endcase
      end
   end

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (chk_en) begin
      cmp("model gate_en", 16'(gate_en), 16'(m_gate));
      cmp("model busy", 16'(busy), 16'(phase != M_IDLE));
      cmp("model cur_domain", 16'(cur_domain), 16'(m_cur));
      cmp("model err_sticky", 16'(err_sticky), 16'(m_err));
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      tick(2);
      rst = 1'b0;
      chk_en = 1;
      cmp("reset gate_en", 16'(gate_en), 16'h0);
      cmp("reset busy", 16'(busy), 16'h0);
      cmp("reset cur_domain", 16'(cur_domain), 16'h0);
      cmp("reset err_sticky", 16'(err_sticky), 16'h0);
      tick(5);
      cmp("quiet gate_en", 16'(gate_en), 16'h0);
      cmp("quiet busy", 16'(busy), 16'h0);
      // two gatings with idle domains: 4 cycles to the first, SETTLE+4 more to the next
      domain_idle = '1;
      req_gate = 9'h005;
      tick(3);
      cmp("gate0 early", 16'(gate_en), 16'h000);
      cmp("gate0 busy", 16'(busy), 16'h1);
      tick(1);
      cmp("gate0 applied", 16'(gate_en), 16'h001);
      cmp("gate0 cur", 16'(cur_domain), 16'h0);
      tick(7);
      cmp("gate2 early", 16'(gate_en), 16'h001);
      tick(1);
      cmp("gate2 applied", 16'(gate_en), 16'h005);
      cmp("gate2 cur", 16'(cur_domain), 16'h2);
      tick(3);
      cmp("settle busy", 16'(busy), 16'h1);
      tick(1);
      cmp("settle done", 16'(busy), 16'h0);
      // ungating ignores idle status, one bit per SETTLE+2 cycles
      req_gate = '1;
      tick(70);
      cmp("all gated", 16'(gate_en), 16'h1FF);
      domain_idle = '0;
      req_gate = '0;
      tick(2);
      cmp("ungate bit0", 16'(gate_en), 16'h1FE);
      tick(6);
      cmp("ungate bit1", 16'(gate_en), 16'h1FC);
      tick(6);
      cmp("ungate bit2", 16'(gate_en), 16'h1F8);
      tick(50);
      cmp("all ungated", 16'(gate_en), 16'h000);
      // timeout on domain 3
      req_gate = 9'h008;
      tick(16);
      cmp("timeout early", 16'(err_sticky), 16'h000);
      tick(1);
      cmp("timeout err", 16'(err_sticky), 16'h008);
      cmp("timeout busy", 16'(busy), 16'h0);
      tick(5);
      cmp("skip holds", 16'(busy), 16'h0);
      cmp("skip gate", 16'(gate_en), 16'h000);
      req_gate = 9'h000;
      tick(1);
      req_gate = 9'h008;
      domain_idle = '1;
      tick(3);
      cmp("retry early", 16'(gate_en), 16'h000);
      tick(1);
      cmp("retry gate", 16'(gate_en), 16'h008);
      cmp("err kept", 16'(err_sticky), 16'h008);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      cmp("err cleared", 16'(err_sticky), 16'h000);
      tick(6);
      // abort while waiting on domain 4
      domain_idle = '0;
      req_gate = 9'h018;
      tick(3);
      cmp("abort waiting", 16'(busy), 16'h1);
      cmp("abort cur", 16'(cur_domain), 16'h4);
      req_gate = 9'h008;
      tick(1);
      cmp("abort idle", 16'(busy), 16'h0);
      cmp("abort gate", 16'(gate_en), 16'h008);
      // single-cycle idle glitch must not gate
      req_gate = 9'h018;
      tick(2);
      domain_idle = 9'h010;
      tick(1);
      domain_idle = '0;
      tick(3);
      cmp("glitch gate", 16'(gate_en), 16'h008);
      cmp("glitch busy", 16'(busy), 16'h1);
      domain_idle = 9'h010;
      tick(2);
      cmp("streak early", 16'(gate_en), 16'h008);
      tick(1);
      cmp("streak gate", 16'(gate_en), 16'h018);
      tick(6);
      // reset during SETTLE
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      domain_idle = '1;
      req_gate = 9'h0F0;
      tick(29);
      cmp("pre-reset gate", 16'(gate_en), 16'h0F0);
      cmp("pre-reset busy", 16'(busy), 16'h1);
      rst = 1'b1;
      tick(1);
      cmp("mid reset gate", 16'(gate_en), 16'h000);
      cmp("mid reset busy", 16'(busy), 16'h0);
      cmp("mid reset err", 16'(err_sticky), 16'h000);
      cmp("mid reset cur", 16'(cur_domain), 16'h0);
      rst = 1'b0;
      // randomized traffic with slowly changing idle and occasional stuck domains
      for (int c = 0; c < 4000; c++) begin
         int b;
         if (c % 400 == 0) stuck = N'($urandom | $urandom);
         if ($urandom_range(7) == 0) begin
            b = $urandom_range(N - 1);
            req_gate[b] = ~req_gate[b];
         end
         domain_idle = (domain_idle ^ (N'($urandom) & N'($urandom) & N'($urandom))) & stuck;
         err_clr = $urandom_range(47) == 0;
         rst = $urandom_range(1499) == 0;
         tick(1);
      end
      rst = 1'b0;
      err_clr = 1'b0;
      tick(5);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
